// File: rtl/gravity_pkg.sv
// Shared types and constants for the gravity scheduler.
// level_period() turns a level into the level-derived drop period. The
// subtraction is done only when it cannot go below the floor.
package gravity_pkg;

  localparam int CNT_W       = 26;
  localparam int LVL_W       = 4;
  localparam int LOCK_RESETS = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FALL,
    S_LOCK,
    S_WAIT,
    S_PAUSE
  } state_t;

  function automatic logic [CNT_W-1:0] level_period(
    input logic [LVL_W-1:0] lvl,
    input int unsigned      base_p,
    input int unsigned      step_p,
    input int unsigned      min_p
  );
    int unsigned dec;
    dec = {{(32-LVL_W){1'b0}}, lvl} * step_p;
    if (base_p <= min_p || dec >= base_p - min_p)
      level_period = CNT_W'(min_p);
    else
      level_period = CNT_W'(base_p - dec);
  endfunction

endpackage

// File: rtl/gravity_scheduler_tick_counter.sv
// tick_counter: up-counter with clear and a terminal compare against limit.
// done pulses on the enabled cycle that finds the count at or past limit; the
// count wraps to 0 on that cycle. Using >= lets a limit that shrinks below the
// running count fire on the next enabled cycle instead of wrapping the counter.
module tick_counter #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt;
  logic         at_limit;

  assign at_limit = (cnt >= limit);
  assign done     = en && !clr && at_limit;

  // Count register: clear has priority, then count or wrap at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= at_limit ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/gravity_scheduler.sv
// gravity_scheduler: drop-period generation, fall/lock timing and levelling.
// Optional feature macro: LOCK_RESET_EN (moves in LOCK restart the lock timer,
// at most LOCK_RESETS times per piece). Without it, moved is ignored.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | game not running or waiting for the first spawn
//   S_FALL  | piece falling, drop_tick every period cycles
//   S_LOCK  | piece resting on the stack, lock timer running
//   S_WAIT  | piece locked, waiting for the next spawn
//   S_PAUSE | frozen; ret_q holds S_FALL or S_LOCK to resume into
module gravity_scheduler
  import gravity_pkg::*;
#(
  parameter int unsigned BASE_PERIOD     = 12_500_000,
  parameter int unsigned LEVEL_STEP      = 500_000,
  parameter int unsigned MIN_PERIOD      = 1_250_000,
  parameter int unsigned SOFT_PERIOD     = 1_250_000,
  parameter int unsigned LOCK_CYCLES     = 12_500_000,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned MAX_LEVEL       = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_active,
  input  logic             pause,
  input  logic             soft_drop,
  input  logic             piece_spawn,
  input  logic             landed,
  input  logic             moved,
  input  logic             lines_valid,
  input  logic [2:0]       lines_cleared,
  output logic             drop_tick,
  output logic             lock_req,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] period
);

  // Accumulator holds < LINES_PER_LEVEL plus up to 7 lines of a single pulse.
  localparam int               ACC_W      = $clog2(LINES_PER_LEVEL + 8);
  localparam logic [ACC_W-1:0] LPL_C      = ACC_W'(LINES_PER_LEVEL);
  localparam logic [LVL_W-1:0] MAX_L      = LVL_W'(MAX_LEVEL);
  localparam logic [CNT_W-1:0] SOFT_P     = CNT_W'(SOFT_PERIOD);
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_CYCLES - 1);

  state_t           state, state_d, ret_q, ret_d, eff;
  logic             tick_d, lock_d;
  logic             act, spawn_go, move_ok, move_take;
  logic             fall_en, fall_clr, fall_done;
  logic             lock_en, lock_clr, lock_done;
  logic [CNT_W-1:0] per_lvl, per_sel, fall_limit;
  logic [ACC_W-1:0] line_acc, line_sum;

  // A released PAUSE behaves as its saved state on that same cycle, so a
  // pause of N cycles delays the timers by exactly N.
  assign eff = (state == S_PAUSE && !pause) ? ret_q : state;
  assign act = game_active && !pause;

  assign spawn_go  = game_active && (eff == S_IDLE || eff == S_WAIT) && piece_spawn;
  assign move_take = act && eff == S_LOCK && landed && move_ok;

  assign fall_en  = act && eff == S_FALL && !landed;
  assign fall_clr = !game_active || spawn_go || (act && eff == S_LOCK && !landed);
  assign lock_en  = act && eff == S_LOCK && landed && !move_ok;
  assign lock_clr = !game_active || (act && eff == S_FALL && landed) || move_take;

  assign per_lvl    = level_period(level, BASE_PERIOD, LEVEL_STEP, MIN_PERIOD);
  assign per_sel    = (soft_drop && per_lvl > SOFT_P) ? SOFT_P : per_lvl;
  assign fall_limit = period - CNT_W'(1);

  tick_counter #(.W(CNT_W)) u_fall_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (fall_en),
    .clr   (fall_clr),
    .limit (fall_limit),
    .done  (fall_done)
  );

  tick_counter #(.W(CNT_W)) u_lock_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (lock_en),
    .clr   (lock_clr),
    .limit (LOCK_LIMIT),
    .done  (lock_done)
  );

`ifdef LOCK_RESET_EN
  localparam int RST_W = $clog2(LOCK_RESETS + 1);
  logic [RST_W-1:0] resets_used;

  assign move_ok = moved && (resets_used < RST_W'(LOCK_RESETS));

  // Lock-reset budget per piece, refilled on every accepted spawn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      resets_used <= '0;
    else if (!game_active || spawn_go)
      resets_used <= '0;
    else if (move_take)
      resets_used <= resets_used + RST_W'(1);
  end
`else
  logic unused_moved;
  assign move_ok      = 1'b0;
  assign unused_moved = moved;
`endif

  // Next-state and strobe decode; game_active low overrides pause.
  always_comb begin
    state_d = state;
    ret_d   = ret_q;
    tick_d  = 1'b0;
    lock_d  = 1'b0;
    if (!game_active) begin
      state_d = S_IDLE;
      ret_d   = S_IDLE;
    end else if (pause && (state == S_FALL || state == S_LOCK)) begin
      state_d = S_PAUSE;
      ret_d   = state;
    end else begin
      state_d = eff;
      case (eff)
        S_IDLE, S_WAIT: begin
          if (piece_spawn) state_d = S_FALL;
        end
        S_FALL: begin
          if (landed) state_d = S_LOCK;
          else        tick_d  = fall_done;
        end
        S_LOCK: begin
          if (!landed) begin
            state_d = S_FALL;
          end else if (lock_done) begin
            state_d = S_WAIT;
            lock_d  = 1'b1;
          end
        end
        default: state_d = state;
      endcase
    end
  end

  // State, registered strobes and the registered active period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ret_q     <= S_IDLE;
      drop_tick <= 1'b0;
      lock_req  <= 1'b0;
      period    <= '0;
    end else begin
      state     <= state_d;
      ret_q     <= ret_d;
      drop_tick <= tick_d;
      lock_req  <= lock_d;
      period    <= per_sel;
    end
  end

  assign line_sum = line_acc + ACC_W'(lines_cleared);

  // Line accumulation; one level per pulse, saturating at MAX_LEVEL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_acc <= '0;
      level    <= '0;
    end else if (!game_active) begin
      line_acc <= '0;
      level    <= '0;
    end else if (lines_valid) begin
      if (line_sum >= LPL_C) begin
        line_acc <= line_sum - LPL_C;
        if (level < MAX_L) level <= level + LVL_W'(1);
      end else begin
        line_acc <= line_sum;
      end
    end
  end

endmodule

// File: tb/tb_gravity_scheduler.sv
// Directed bench for gravity_scheduler with small timing parameters:
// BASE=100, STEP=10, MIN=20, SOFT=5, LOCK=30, LINES_PER_LEVEL=10, MAX=15.
module tb_gravity_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_active = 1'b0;
  logic        pause = 1'b0;
  logic        soft_drop = 1'b0;
  logic        piece_spawn = 1'b0;
  logic        landed = 1'b0;
  logic        moved = 1'b0;
  logic        lines_valid = 1'b0;
  logic [2:0]  lines_cleared = 3'd0;
  logic        drop_tick, lock_req;
  logic [3:0]  level;
  logic [25:0] period;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gravity_scheduler #(
    .BASE_PERIOD     (100),
    .LEVEL_STEP      (10),
    .MIN_PERIOD      (20),
    .SOFT_PERIOD     (5),
    .LOCK_CYCLES     (30),
    .LINES_PER_LEVEL (10),
    .MAX_LEVEL       (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .game_active   (game_active),
    .pause         (pause),
    .soft_drop     (soft_drop),
    .piece_spawn   (piece_spawn),
    .landed        (landed),
    .moved         (moved),
    .lines_valid   (lines_valid),
    .lines_cleared (lines_cleared),
    .drop_tick     (drop_tick),
    .lock_req      (lock_req),
    .level         (level),
    .period        (period)
  );

  // Counts edges until the chosen strobe appears (n = -1 on timeout);
  // other counts the opposite strobe seen meanwhile.
  task automatic wait_pulse(input bit use_lock, input int max_cyc,
                            output int n, output int other);
    bit hit;
    hit = 1'b0; n = 0; other = 0;
    while (!hit && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
      hit = use_lock ? lock_req : drop_tick;
      if (use_lock ? drop_tick : lock_req) other++;
    end
    if (!hit) n = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (drop_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b expected 0", drop_tick); end
    checks++; if (lock_req !== 1'b0) begin errors++; $display("FAIL reset_lock: got %0b expected 0", lock_req); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (period !== 26'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period); end
    rst = 1'b0;
    game_active = 1'b1;
    @(posedge clk); #1;
    checks++; if (period !== 26'd100) begin errors++; $display("FAIL period_l0: got %0d expected 100", period); end
  endtask

  task automatic test_fall();
    int n, o;
    piece_spawn = 1'b1;
    @(posedge clk); #1;
    piece_spawn = 1'b0;
    wait_pulse(0, 150, n, o);
    checks++; if (n != 100) begin errors++; $display("FAIL fall_first: got %0d expected 100", n); end
    checks++; if (period !== 26'd100) begin errors++; $display("FAIL fall_period: got %0d expected 100", period); end
    wait_pulse(0, 150, n, o);
    checks++; if (n != 100) begin errors++; $display("FAIL fall_spacing: got %0d expected 100", n); end
  endtask

  task automatic test_soft();
    int n, o;
    repeat (50) @(posedge clk);
    #1;
    soft_drop = 1'b1;
    wait_pulse(0, 150, n, o);
    checks++; if (n != 2) begin errors++; $display("FAIL soft_shrink: got %0d expected 2", n); end
    checks++; if (period !== 26'd5) begin errors++; $display("FAIL soft_period: got %0d expected 5", period); end
    for (int i = 0; i < 2; i++) begin
      wait_pulse(0, 50, n, o);
      checks++; if (n != 5) begin errors++; $display("FAIL soft_spacing: got %0d expected 5", n); end
    end
    soft_drop = 1'b0;
    wait_pulse(0, 150, n, o);
    checks++; if (n != 100) begin errors++; $display("FAIL soft_release: got %0d expected 100", n); end
    checks++; if (period !== 26'd100) begin errors++; $display("FAIL soft_release_period: got %0d expected 100", period); end
  endtask

  task automatic test_lock();
    int n, o, quiet;
    repeat (99) @(posedge clk);
    #1;
    landed = 1'b1;
    @(posedge clk); #1;
    checks++; if (drop_tick !== 1'b0) begin errors++; $display("FAIL land_priority: got %0b expected 0", drop_tick); end
    wait_pulse(1, 60, n, o);
    checks++; if (n != 30) begin errors++; $display("FAIL lock_delay: got %0d expected 30", n); end
    checks++; if (o != 0) begin errors++; $display("FAIL lock_no_tick: got %0d expected 0", o); end
    quiet = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (drop_tick || lock_req) quiet++;
    end
    checks++; if (quiet != 0) begin errors++; $display("FAIL wait_quiet: got %0d strobes expected 0", quiet); end
    landed = 1'b0;
  endtask

  task automatic test_lock_cancel();
    int n, o;
    piece_spawn = 1'b1;
    @(posedge clk); #1;
    piece_spawn = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    landed = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    landed = 1'b0;
    @(posedge clk); #1;
    wait_pulse(0, 150, n, o);
    checks++; if (n != 100) begin errors++; $display("FAIL lock_cancel: got %0d expected 100", n); end
    checks++; if (o != 0) begin errors++; $display("FAIL lock_cancel_lock: got %0d expected 0", o); end
  endtask

  task automatic test_lock_reset();
    int n, ticks, exp_n;
    bit hit;
`ifdef LOCK_RESET_EN
    exp_n = 180;
`else
    exp_n = 30;
`endif
    landed = 1'b1;
    @(posedge clk); #1;
    n = 0; ticks = 0; hit = 1'b0;
    while (!hit && n < 250) begin
      moved = ((n + 1) % 10 == 0) && (n + 1 <= 160);
      @(posedge clk); #1;
      n++;
      hit = lock_req;
      if (drop_tick) ticks++;
    end
    moved = 1'b0;
    if (!hit) n = -1;
    checks++; if (n != exp_n) begin errors++; $display("FAIL lock_moves: got %0d expected %0d", n, exp_n); end
    checks++; if (ticks != 0) begin errors++; $display("FAIL lock_moves_tick: got %0d expected 0", ticks); end
    landed = 1'b0;
  endtask

  task automatic test_pause();
    int n, o, ticks;
    piece_spawn = 1'b1;
    @(posedge clk); #1;
    piece_spawn = 1'b0;
    ticks = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (drop_tick) ticks++;
    end
    pause = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (drop_tick || lock_req) ticks++;
    end
    pause = 1'b0;
    checks++; if (ticks != 0) begin errors++; $display("FAIL pause_quiet: got %0d expected 0", ticks); end
    wait_pulse(0, 150, n, o);
    checks++; if (n != 70) begin errors++; $display("FAIL pause_delay: got %0d expected 70", n); end
  endtask

  task automatic test_level();
    int exp_lvl, exp_per;
    for (int p = 1; p <= 43; p++) begin
      lines_cleared = 3'd4;
      lines_valid = 1'b1;
      @(posedge clk); #1;
      lines_valid = 1'b0;
      lines_cleared = 3'd0;
      exp_lvl = (4 * p) / 10;
      if (exp_lvl > 15) exp_lvl = 15;
      checks++; if (int'(level) != exp_lvl) begin errors++; $display("FAIL level_p%0d: got %0d expected %0d", p, level, exp_lvl); end
      @(posedge clk); #1;
      exp_per = 100 - 10 * exp_lvl;
      if (exp_per < 20) exp_per = 20;
      checks++; if (int'(period) != exp_per) begin errors++; $display("FAIL period_p%0d: got %0d expected %0d", p, period, exp_per); end
      if (p == 38) begin
        soft_drop = 1'b1;
        @(posedge clk); #1;
        checks++; if (period !== 26'd5) begin errors++; $display("FAIL soft_at_max: got %0d expected 5", period); end
        soft_drop = 1'b0;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_game_over();
    int n, o, quiet;
    game_active = 1'b0;
    @(posedge clk); #1;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL over_level: got %0d expected 0", level); end
    checks++; if (drop_tick !== 1'b0 || lock_req !== 1'b0) begin errors++; $display("FAIL over_strobe: got %0b%0b expected 00", drop_tick, lock_req); end
    @(posedge clk); #1;
    checks++; if (period !== 26'd100) begin errors++; $display("FAIL over_period: got %0d expected 100", period); end
    game_active = 1'b1;
    quiet = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (drop_tick || lock_req) quiet++;
    end
    checks++; if (quiet != 0) begin errors++; $display("FAIL idle_quiet: got %0d expected 0", quiet); end
    piece_spawn = 1'b1;
    @(posedge clk); #1;
    piece_spawn = 1'b0;
    wait_pulse(0, 150, n, o);
    checks++; if (n != 100) begin errors++; $display("FAIL restart_fall: got %0d expected 100", n); end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_soft();
    test_lock();
    test_lock_cancel();
    test_lock_reset();
    test_pause();
    test_level();
    test_game_over();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
